// File: rtl/mux4_rr_sched_pkg.sv
// Shared types and constants for the 4-way round-robin mux scheduler.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    // IDLE: no owner; OWN: gnt[sel] asserted; TURN: one dead cycle between owners.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Rotating-priority encoder: first set req bit scanning ptr, ptr+1, .. ptr+3 (mod 4).
// Latency: purely combinational.
// Backpressure: none; valid=0 when no bit of req is set.
import mux_sched_pkg::*;

module rr_pick4 (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of a shared 4:1 mux select; bounded tenure, registered mux output.
// Latency: grant 1 cycle after request in IDLE; y is din[sel] delayed 1 cycle, aligned with gnt.
// Backpressure: en=0 freezes all state and outputs; requests are level and held until done.
import mux_sched_pkg::*;

module mux4_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter bit TURN_GAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             y_n;

    logic [N_REQ-1:0] pick_req;
    logic             pick_vld;
    logic [SEL_W-1:0] pick_idx;

    // While owning, the current owner is masked so the picker only sees contenders.
    always_comb begin
        pick_req = req;
        if (state == OWN) begin
            pick_req = req & ~onehot(sel);
        end
    end

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Next-state, tenure counter, pointer, select and output data decisions.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = OWN;
                    sel_n   = pick_idx;
                    ptr_n   = pick_idx + SEL_W'(1);
                    cnt_n   = CNT_ONE;
                end
            end
            OWN: begin
                if (!req[sel] || (cnt == MAX_CNT && pick_vld)) begin
                    // Owner released or its tenure expired with contenders waiting.
                    if (pick_vld) begin
                        state_n = TURN_GAP ? TURN : OWN;
                        sel_n   = pick_idx;
                        ptr_n   = pick_idx + SEL_W'(1);
                        cnt_n   = TURN_GAP ? '0 : CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (cnt == MAX_CNT) begin
                    // Sole requester: fresh tenure without a gap.
                    cnt_n = CNT_ONE;
                end else if (cnt < MAX_CNT) begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            TURN: begin
                if (req[sel]) begin
                    state_n = OWN;
                    cnt_n   = CNT_ONE;
                end else if (pick_vld) begin
                    // Incoming owner gave up during the gap; hand to the next in line.
                    state_n = OWN;
                    sel_n   = pick_idx;
                    ptr_n   = pick_idx + SEL_W'(1);
                    cnt_n   = CNT_ONE;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        y_n = (state_n == OWN) ? din[sel_n] : 1'b0;
    end

    // State registers; reset wins over en, en=0 holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            y     <= 1'b0;
        end else if (en) begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            y     <= y_n;
        end
    end

    assign busy = (state == OWN);
    assign gnt  = busy ? onehot(sel) : '0;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: one instance with a handover gap, one without.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled 1 unit after it.
// Backpressure: en is exercised directly as the freeze control.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic [3:0] din;

    logic [3:0] gnt1, gnt0;
    logic [1:0] sel1, sel0;
    logic       y1, y0;
    logic       busy1, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(.MAX_HOLD(4), .TURN_GAP(1'b1)) dut_gap (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .din   (din),
        .gnt   (gnt1),
        .sel   (sel1),
        .y     (y1),
        .busy  (busy1)
    );

    mux4_rr_sched #(.MAX_HOLD(4), .TURN_GAP(1'b0)) dut_nogap (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .din   (din),
        .gnt   (gnt0),
        .sel   (sel0),
        .y     (y0),
        .busy  (busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Full output check of the gap instance.
    task automatic chk_gap(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic yy, input logic b);
        chk({tag, ".gnt"},  gnt1, g);
        chk({tag, ".sel"},  {2'b00, sel1}, {2'b00, s});
        chk({tag, ".y"},    {3'b000, y1}, {3'b000, yy});
        chk({tag, ".busy"}, {3'b000, busy1}, {3'b000, b});
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] k;
        reset = 1'b1;
        en    = 1'b1;
        req   = 4'b1111;
        din   = 4'b1111;

        // T1: reset held two cycles with all requests up.
        tick();
        chk_gap("t1_rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_gap("t1_rst_c2", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("t1_nogap_gnt", gnt0, 4'b0000);

        // T2: lone requester 2, regranted without a gap, y tracks din[2] one cycle late.
        reset = 1'b0;
        req   = 4'b0100;
        din   = 4'b0100;
        tick();
        chk_gap("t2_grant", 4'b0100, 2'd2, 1'b1, 1'b1);
        din = 4'b1011;
        tick();
        chk_gap("t2_cnt2", 4'b0100, 2'd2, 1'b0, 1'b1);
        din = 4'b0100;
        tick();
        chk_gap("t2_cnt3", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        chk_gap("t2_cnt4", 4'b0100, 2'd2, 1'b1, 1'b1);
        din = 4'b0000;
        tick();
        chk_gap("t2_regrant", 4'b0100, 2'd2, 1'b0, 1'b1);

        // T3: everyone requesting; 4-cycle tenures, one dead cycle between owners.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        din   = 4'b1111;
        tick();
        k = 2'd0;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << k;
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("t3_own%0d_c%0d", i, c), gnt1, exp_g);
                chk($sformatf("t3_sel%0d_c%0d", i, c), {2'b00, sel1}, {2'b00, k});
                tick();
            end
            k = k + 2'd1;
            chk_gap($sformatf("t3_turn%0d", i), 4'b0000, k, 1'b0, 1'b0);
            tick();
        end

        // T4: owner 1 releases after 2 cycles with requester 3 waiting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1010;
        din   = 4'b1000;
        tick();
        chk("t4_gap_own1", gnt1, 4'b0010);
        chk("t4_nogap_own1", gnt0, 4'b0010);
        tick();
        chk("t4_gap_own1_c2", gnt1, 4'b0010);
        req = 4'b1000;
        tick();
        chk_gap("t4_gap_turn", 4'b0000, 2'd3, 1'b0, 1'b0);
        chk("t4_nogap_direct", gnt0, 4'b1000);
        chk("t4_nogap_sel", {2'b00, sel0}, 4'd3);
        chk("t4_nogap_y", {3'b000, y0}, 4'd1);
        tick();
        chk_gap("t4_gap_own3", 4'b1000, 2'd3, 1'b1, 1'b1);

        // T5: freeze mid-tenure (owner 3, cnt=2) while inputs toggle.
        tick();
        chk_gap("t5_pre", 4'b1000, 2'd3, 1'b1, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = (i % 2 == 0) ? 4'b0111 : 4'b1000;
            req = (i % 2 == 0) ? 4'b0111 : 4'b0001;
            tick();
            chk_gap($sformatf("t5_frozen%0d", i), 4'b1000, 2'd3, 1'b1, 1'b1);
        end
        // Resuming from cnt=2 with requester 0 waiting: two more owned cycles, then the gap.
        en  = 1'b1;
        req = 4'b1001;
        din = 4'b1000;
        tick();
        chk_gap("t5_resume_c3", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick();
        chk_gap("t5_resume_c4", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick();
        chk_gap("t5_rotate_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk("t5_own0", gnt1, 4'b0001);

        // T6: bring owner 3 back, then reset mid-tenure; ptr returns to requester 0.
        req = 4'b1000;
        tick();
        chk_gap("t6_turn3", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick();
        chk_gap("t6_own3", 4'b1000, 2'd3, 1'b1, 1'b1);
        reset = 1'b1;
        req   = 4'b1001;
        din   = 4'b0001;
        tick();
        chk_gap("t6_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_gap("t6_regrant0", 4'b0001, 2'd0, 1'b1, 1'b1);
        chk("t6_nogap_regrant0", gnt0, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
